// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding RV32I load/store against an internal word RAM,
// with a programmable wait-state count between request accept and response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // WAIT lasts WAIT_CYCLES+1 cycles so the response lands WAIT_CYCLES+1 edges after accept.
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          commit;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wr_data;

  assign req_ready = rst && (state_q == StIdle);
  assign commit    = (state_q == StWait) && (cnt_q == 4'd0);
  assign idx       = addr_q[AW+1:2];
  assign rd_word   = mem[idx];
  assign byte_sel  = rd_word >> {addr_q[1:0], 3'b000};
  assign half_sel  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    acc_err = 1'b0;
    if (we_q) begin
      if (f3_q[2] || (f3_q[1:0] == 2'b11)) acc_err = 1'b1;
    end else if ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11)) begin
      acc_err = 1'b1;
    end
    if ((f3_q[1:0] == 2'b01) && addr_q[0]) acc_err = 1'b1;
    if ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)) acc_err = 1'b1;
    if (32'(addr_q[31:2]) >= DEPTH_WORDS) acc_err = 1'b1;
  end

  always_comb begin
    load_data = 32'd0;
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel[7:0]};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, byte_sel[7:0]};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    be      = 4'b1111;
    wr_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  // RAM is not reset; a store only lands on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= WaitInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
